sci_vol_ctrl: RTL and testbench
===============================

# sci_vol_ctrl

Serial control interface (SCI) sequencer for the audio decoder chip. After reset it writes an initialisation sequence (MODE, CLOCKF, VOL). It then tracks the 16-bit volume word from the volume-setting block and issues an SCI_VOL write whenever that word changes. It also owns the shared SPI pins and grants them to the SDI data feeder between SCI transactions.

## Interface
- CLK_DIV, 4: SCK half-period in CLK cycles (SCK = CLK / (2*CLK_DIV)); legal range 2..255
- INIT_MODE, 16'h0800: value written to SCI_MODE during init
- INIT_CLOCKF, 16'h9800: value written to SCI_CLOCKF during init
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- VOL  in  16  requested volume word, {left, right} attenuation
- DREQ  in  1  decoder ready; a frame may start only while DREQ=1
- SDI_REQ  in  1  SDI feeder requests the SPI bus; held for the whole burst
- SDI_GNT  out  1  bus granted to SDI feeder
- XCS  out  1  SCI chip select, active low
- SCK  out  1  SPI clock, idle low
- MOSI  out  1  SPI data, MSB first
- BUSY  out  1  SCI frame pending or in progress
- INIT_DONE  out  1  init sequence complete; sticky until RST

## Operation
- Frame: 32 bits = {8'h02 write opcode, 8-bit address, 16-bit data}. Addresses: MODE 8'h00, CLOCKF 8'h03, VOL 8'h0B.
- FSM states: INIT_WAIT, LOAD, SHIFT, GAP, IDLE, SDI.
- INIT_WAIT: wait for DREQ=1, then LOAD the next init word, in order MODE → CLOCKF → VOL. The VOL word uses VOL as sampled in LOAD. After the third GAP: INIT_DONE=1, go to IDLE.
- LOAD (1 cycle): latch the frame into the shift register and copy the data word to the shadow register when address=VOL. XCS falls and bit31 drives MOSI at the end of LOAD.
- SHIFT: each bit is SCK=0 for CLK_DIV cycles, then SCK=1 for CLK_DIV cycles. MOSI changes only on SCK falling or at frame start; the decoder samples on the rising edge. Shifting ends after 32 bits, with SCK low.
- GAP: XCS=1 and SCK=0 for CLK_DIV cycles, then go to INIT_WAIT (during init) or IDLE.
- IDLE, evaluated in priority order:
  - pending = (VOL != shadow). If pending and DREQ=1, go to LOAD with the VOL frame.
  - Otherwise, if SDI_REQ=1, go to SDI.
  - If pending and DREQ=0, stay in IDLE. SDI_REQ is not granted while a volume write is pending.
- SDI: SDI_GNT=1. XCS, SCK and MOSI are held at idle values (XCS=1, SCK=0, MOSI=0). When SDI_REQ=0 is sampled, SDI_GNT drops on the next cycle and the FSM returns to IDLE. VOL changes during SDI only set pending.
- VOL changes during SHIFT or GAP do not alter the frame in flight. They are caught by the next compare in IDLE, so the last value always gets written; intermediate values may be skipped.
- BUSY = 1 in INIT_WAIT, LOAD, SHIFT and GAP, and 1 in IDLE while pending; otherwise 0.

## Timing
- Reset values: XCS=1, SCK=0, MOSI=0, SDI_GNT=0, BUSY=1, INIT_DONE=0, shadow=16'h0000, FSM=INIT_WAIT, init index=0.
- RST mid-frame or mid-grant takes effect on the next edge: XCS high, SCK low, SDI_GNT low, init restarts from MODE.
- Frame length: 1 (LOAD) + 64*CLK_DIV (SHIFT, XCS low) + CLK_DIV (GAP) cycles.
- Latency: a VOL change sampled in IDLE with DREQ=1 produces LOAD on the next cycle; XCS goes low 2 cycles after the change edge.
- A grant takes 1 cycle after SDI_REQ is sampled in IDLE, and release takes 1 cycle. There is never overlap: SDI_GNT=1 implies XCS=1.
- DREQ is sampled only in INIT_WAIT and IDLE. DREQ falling mid-frame is ignored.

## Structure
- Shared package sci_pkg holds:
  - opcode constant SCI_WR=8'h02
  - address constants SCI_MODE, SCI_CLOCKF, SCI_VOL
  - the FSM state encoding
- One sub-module, spi_tx32: a 32-bit MSB-first serializer with CLK_DIV divider, start pulse and done pulse. The controller keeps the FSM, shadow register, arbitration and init index.

## Test plan
- Reset, DREQ=1, VOL=16'h2020 → three frames on MOSI: 32'h02000800, 32'h02039800, 32'h020B2020. INIT_DONE rises after the third GAP; each XCS low period is exactly 64*CLK_DIV cycles.
- After init, VOL 16'h2020→16'h3030 with DREQ=1 → XCS low 2 cycles later, frame 32'h020B3030, BUSY high from the change until GAP ends.
- DREQ=0 plus VOL change plus SDI_REQ=1 → no frame and no grant. Raising DREQ → VOL frame first, then SDI_GNT=1 one cycle after returning to IDLE.
- SDI_GNT=1, VOL stepped 0x1010→0x2020→0x3030, then SDI_REQ=0 → SDI_GNT low next cycle, then exactly one frame with data 16'h3030.
- VOL changed mid-SHIFT → the in-flight frame carries the old value, and a second frame with the new value follows after GAP.
- RST pulsed mid-SHIFT → XCS=1 and SCK=0 on the next edge, INIT_DONE=0, init sequence restarts with the MODE frame.

Source files
------------

// File: rtl/sci_pkg.sv
// Shared SCI constants, controller state encoding and init-address lookup.
package sci_pkg;

    localparam logic [7:0] SCI_WR     = 8'h02;
    localparam logic [7:0] SCI_MODE   = 8'h00;
    localparam logic [7:0] SCI_CLOCKF = 8'h03;
    localparam logic [7:0] SCI_VOL    = 8'h0B;

    typedef enum logic [2:0] {
        StInitWait,
        StLoad,
        StShift,
        StGap,
        StIdle,
        StSdi
    } sci_state_e;

    // Init order: MODE, CLOCKF, VOL.
    function automatic logic [7:0] init_addr(input logic [1:0] idx);
        case (idx)
            2'd0:    return SCI_MODE;
            2'd1:    return SCI_CLOCKF;
            default: return SCI_VOL;
        endcase
    endfunction

endpackage

// File: rtl/spi_tx32.sv
// 32-bit MSB-first SPI serializer: SCK low then high for CLK_DIV cycles per bit.
module spi_tx32 #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [31:0] i_data,
    output logic        o_cs_n,
    output logic        o_sck,
    output logic        o_mosi,
    output logic        o_done
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [30:0] r_shift;
    logic [7:0]  r_div;
    logic [5:0]  r_half;
    logic        r_active;
    logic        r_sck;
    logic        r_mosi;
    logic        w_tick;

    assign w_tick = r_active && (r_div == DIV_LAST);
    // High on the final cycle of the last SCK-high half period.
    assign o_done = w_tick && (r_half == 6'd63);
    assign o_cs_n = ~r_active;
    assign o_sck  = r_sck;
    assign o_mosi = r_mosi;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shift  <= '0;
            r_div    <= '0;
            r_half   <= '0;
            r_active <= 1'b0;
            r_sck    <= 1'b0;
            r_mosi   <= 1'b0;
        end else if (i_start) begin
            r_shift  <= i_data[30:0];
            r_div    <= '0;
            r_half   <= '0;
            r_active <= 1'b1;
            r_sck    <= 1'b0;
            r_mosi   <= i_data[31];
        end else if (r_active) begin
            r_div <= w_tick ? '0 : r_div + 8'd1;
            if (w_tick) begin
                r_half <= r_half + 6'd1;
                if (!r_half[0]) begin
                    r_sck <= 1'b1;
                end else if (o_done) begin
                    r_sck    <= 1'b0;
                    r_mosi   <= 1'b0;
                    r_active <= 1'b0;
                end else begin
                    r_sck   <= 1'b0;
                    r_mosi  <= r_shift[30];
                    r_shift <= {r_shift[29:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: rtl/sci_vol_ctrl.sv
// SCI sequencer: init writes, volume tracking via shadow register, SPI bus arbitration
// between SCI frames and the SDI feeder.
module sci_vol_ctrl
    import sci_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 4,
    parameter logic [15:0] INIT_MODE   = 16'h0800,
    parameter logic [15:0] INIT_CLOCKF = 16'h9800
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_vol,
    input  logic        i_dreq,
    input  logic        i_sdi_req,
    output logic        o_sdi_gnt,
    output logic        o_xcs,
    output logic        o_sck,
    output logic        o_mosi,
    output logic        o_busy,
    output logic        o_init_done
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    sci_state_e  r_state;
    logic [1:0]  r_init_idx;
    logic        r_init_done;
    logic [15:0] r_shadow;
    logic        r_sdi_gnt;
    logic [7:0]  r_gap_cnt;

    logic        w_pending;
    logic        w_load;
    logic        w_tx_done;
    logic [7:0]  w_addr;
    logic [15:0] w_data;

    assign w_pending = (i_vol != r_shadow);
    assign w_load    = (r_state == StLoad);
    assign w_addr    = r_init_done ? SCI_VOL : init_addr(r_init_idx);
    assign w_data    = (w_addr == SCI_MODE)   ? INIT_MODE   :
                       (w_addr == SCI_CLOCKF) ? INIT_CLOCKF : i_vol;

    assign o_busy      = (r_state == StIdle) ? w_pending : (r_state != StSdi);
    assign o_sdi_gnt   = r_sdi_gnt;
    assign o_init_done = r_init_done;

    spi_tx32 #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (w_load),
        .i_data  ({SCI_WR, w_addr, w_data}),
        .o_cs_n  (o_xcs),
        .o_sck   (o_sck),
        .o_mosi  (o_mosi),
        .o_done  (w_tx_done)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StInitWait;
            r_init_idx  <= 2'd0;
            r_init_done <= 1'b0;
            r_shadow    <= 16'h0000;
            r_sdi_gnt   <= 1'b0;
            r_gap_cnt   <= '0;
        end else begin
            case (r_state)
                StInitWait: if (i_dreq) r_state <= StLoad;
                StLoad: begin
                    if (w_addr == SCI_VOL) r_shadow <= i_vol;
                    r_state <= StShift;
                end
                StShift: begin
                    if (w_tx_done) begin
                        r_state   <= StGap;
                        r_gap_cnt <= '0;
                    end
                end
                StGap: begin
                    if (r_gap_cnt == DIV_LAST) begin
                        if (r_init_done) begin
                            r_state <= StIdle;
                        end else if (r_init_idx == 2'd2) begin
                            r_init_done <= 1'b1;
                            r_state     <= StIdle;
                        end else begin
                            r_init_idx <= r_init_idx + 2'd1;
                            r_state    <= StInitWait;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 8'd1;
                    end
                end
                // A pending volume write always wins over the SDI feeder.
                StIdle: begin
                    if (w_pending && i_dreq) begin
                        r_state <= StLoad;
                    end else if (!w_pending && i_sdi_req) begin
                        r_state   <= StSdi;
                        r_sdi_gnt <= 1'b1;
                    end
                end
                StSdi: begin
                    if (!i_sdi_req) begin
                        r_state   <= StIdle;
                        r_sdi_gnt <= 1'b0;
                    end
                end
                default: r_state <= StInitWait;
            endcase
        end
    end

endmodule

// File: tb/tb_sci_vol_ctrl.sv
// Bench for sci_vol_ctrl: frame-timeline reference model checked every cycle, plus
// directed scenarios with literal frame/latency expectations and a random phase.
module tb_sci_vol_ctrl;

    localparam int D  = 4;
    localparam int MI = 0;
    localparam int MD = 1;
    localparam int MS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dreq = 1'b1;
    logic        sdi_req = 1'b0;
    logic [15:0] vol = 16'h2020;
    logic        xcs, sck, mosi, gnt, busy, done;

    always #5 clk = ~clk;

    sci_vol_ctrl #(
        .CLK_DIV     (D),
        .INIT_MODE   (16'h0800),
        .INIT_CLOCKF (16'h9800)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_vol       (vol),
        .i_dreq      (dreq),
        .i_sdi_req   (sdi_req),
        .o_sdi_gnt   (gnt),
        .o_xcs       (xcs),
        .o_sck       (sck),
        .o_mosi      (mosi),
        .o_busy      (busy),
        .o_init_done (done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model: m_k is the cycle index inside a frame (0 = LOAD), -1 when none.
    int          m_k = -1;
    int          m_mode = MI;
    int          m_idx = 0;
    bit          m_done = 0, m_gnt = 0, m_valid = 0;
    logic [15:0] m_shadow = 16'h0;
    logic [31:0] m_frame = 32'h0;

    logic [31:0] mon_sr = 32'h0;
    int          mon_bits = 0, mon_low = 0;
    logic        prev_sck = 1'b0;
    logic [31:0] frames[$];
    int          lows[$];

    always @(posedge clk) begin
        logic [7:0]  a;
        logic [15:0] dt;
        bit          in_sh, e_sck, e_mosi, e_busy;
        if (rst) begin
            m_k = -1; m_mode = MI; m_idx = 0; m_done = 0; m_gnt = 0;
            m_shadow = 16'h0; m_valid = 1;
        end else if (m_valid) begin
            if (m_k == 0) begin
                a  = m_done ? 8'h0B : (m_idx == 0 ? 8'h00 : (m_idx == 1 ? 8'h03 : 8'h0B));
                dt = (a == 8'h00) ? 16'h0800 : ((a == 8'h03) ? 16'h9800 : vol);
                if (a == 8'h0B) m_shadow = vol;
                m_frame = {8'h02, a, dt};
                m_k = 1;
            end else if (m_k == 65 * D) begin
                m_k = -1;
                if (!m_done) begin
                    m_idx++;
                    if (m_idx == 3) begin m_done = 1; m_mode = MD; end
                    else m_mode = MI;
                end else m_mode = MD;
            end else if (m_k > 0) begin
                m_k++;
            end else if (m_mode == MI) begin
                if (dreq) m_k = 0;
            end else if (m_mode == MD) begin
                if (vol != m_shadow && dreq) m_k = 0;
                else if (vol == m_shadow && sdi_req) begin m_mode = MS; m_gnt = 1; end
            end else if (!sdi_req) begin
                m_mode = MD; m_gnt = 0;
            end
        end
        #1;
        if (m_valid) begin
            in_sh  = (m_k >= 1 && m_k <= 64 * D);
            e_sck  = in_sh && (((m_k - 1) / D) % 2 == 1);
            e_mosi = in_sh ? m_frame[31 - ((m_k - 1) / (2 * D))] : 1'b0;
            e_busy = (m_k >= 0) || (m_mode == MI) || (m_mode == MD && vol != m_shadow);
            check($sformatf("cycle t=%0t {xcs,sck,mosi,gnt,busy,done}", $time),
                  {26'd0, xcs, sck, mosi, gnt, busy, done},
                  {26'd0, !in_sh, e_sck, e_mosi, m_gnt, e_busy, m_done});
        end
        if (xcs) begin
            if (mon_low > 0) lows.push_back(mon_low);
            mon_low = 0; mon_bits = 0;
        end else begin
            mon_low++;
            if (sck && !prev_sck) begin
                mon_sr = {mon_sr[30:0], mosi};
                mon_bits++;
                if (mon_bits == 32) frames.push_back(mon_sr);
            end
        end
        prev_sck = sck;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_frames(input int n, input int budget, input string name);
        int c = 0;
        while (frames.size() < n && c < budget) begin @(negedge clk); c++; end
        check(name, frames.size(), n);
    endtask

    task automatic check_frame(input string name, input logic [31:0] exp);
        if (frames.size() > 0) check(name, frames.pop_front(), exp);
        else check(name, 'x, exp);
    endtask

    task automatic wait_done(input string name, input int exp);
        int c = 0;
        while (!done && c < 2000) begin @(negedge clk); c++; end
        check(name, c, exp);
    endtask

    initial begin
        int b, lat, xl;
        tick(2);
        check("reset xcs", xcs, 1);
        check("reset sck", sck, 0);
        check("reset gnt", gnt, 0);
        check("reset busy", busy, 1);
        check("reset init_done", done, 0);
        rst = 1'b0;
        // Three frames of 261 cycles, each preceded by one INIT_WAIT cycle.
        wait_done("init_done latency", 786);
        check_frame("init frame MODE", 32'h02000800);
        check_frame("init frame CLOCKF", 32'h02039800);
        check_frame("init frame VOL", 32'h020B2020);
        for (int i = 0; i < 3; i++) check($sformatf("init xcs low %0d", i), lows[i], 64 * D);
        frames.delete(); lows.delete();

        vol = 16'h3030;
        #1;
        b = 0; lat = -1;
        while (busy && b < 1000) begin
            if (!xcs && lat < 0) lat = b;
            @(negedge clk); b++;
        end
        check("vol change xcs latency", lat, 2);
        check("vol change busy cycles", b, 262);
        check_frame("vol frame 3030", 32'h020B3030);
        check("vol frame xcs low", lows.size() > 0 ? lows.pop_front() : -1, 256);

        dreq = 1'b0; vol = 16'h4040; sdi_req = 1'b1;
        xl = 0;
        repeat (20) begin @(negedge clk); if (!xcs) xl++; end
        check("dreq low no frame", xl, 0);
        check("dreq low no grant", gnt, 0);
        check("dreq low busy", busy, 1);
        dreq = 1'b1;
        b = 0;
        while (!gnt && b < 600) begin @(negedge clk); b++; end
        check("grant after vol frame", b, 263);
        check_frame("pending frame 4040", 32'h020B4040);

        vol = 16'h1010; tick(3);
        vol = 16'h2020; tick(3);
        vol = 16'h3030; tick(3);
        check("sdi holds grant", gnt, 1);
        check("sdi no frame", frames.size(), 0);
        check("sdi busy low", busy, 0);
        sdi_req = 1'b0;
        tick(1);
        check("sdi release", gnt, 0);
        wait_frames(1, 600, "frame after sdi");
        tick(300);
        check("single frame after sdi", frames.size(), 1);
        check_frame("frame after sdi 3030", 32'h020B3030);

        frames.delete();
        vol = 16'h5050; tick(50);
        vol = 16'h6060;
        wait_frames(2, 1200, "mid-shift two frames");
        check_frame("in-flight frame old value", 32'h020B5050);
        check_frame("follow-up frame new value", 32'h020B6060);
        tick(10);

        vol = 16'h7070; tick(40);
        rst = 1'b1; tick(1);
        check("mid-frame reset xcs", xcs, 1);
        check("mid-frame reset sck", sck, 0);
        check("mid-frame reset init_done", done, 0);
        frames.delete(); lows.delete();
        rst = 1'b0;
        wait_done("re-init latency", 786);
        check_frame("re-init MODE", 32'h02000800);
        check_frame("re-init CLOCKF", 32'h02039800);
        check_frame("re-init VOL", 32'h020B7070);

        for (int i = 0; i < 15000; i++) begin
            rst  = ($urandom_range(0, 4999) == 0);
            dreq = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) vol = 16'($urandom);
            if (sdi_req) begin
                if ($urandom_range(0, 39) == 0) sdi_req = 1'b0;
            end else if ($urandom_range(0, 59) == 0) begin
                sdi_req = 1'b1;
            end
            @(negedge clk);
        end
        rst = 1'b0;
        tick(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
